// File: rtl/fbcpu_pkg.sv
// Shared opcode numbering, FSM state encoding and decode helpers for the FB-CPU v2 core.
// Opcodes are carried as 32-bit zero-extended values so the opcode field width stays a free parameter.
package fbcpu_pkg;

  localparam logic [31:0] OP_LOAD    = 32'd0;
  localparam logic [31:0] OP_STORE   = 32'd1;
  localparam logic [31:0] OP_ADD     = 32'd2;
  localparam logic [31:0] OP_SUB     = 32'd3;
  localparam logic [31:0] OP_MUL     = 32'd4;
  localparam logic [31:0] OP_AND     = 32'd5;
  localparam logic [31:0] OP_JMP     = 32'd6;
  localparam logic [31:0] OP_JZ      = 32'd7;
  localparam logic [31:0] OP_NOP     = 32'd8;
  localparam logic [31:0] OP_HALT    = 32'd9;
  localparam logic [31:0] OP_JNZ     = 32'd10;
  localparam logic [31:0] OP_JC      = 32'd11;
  localparam logic [31:0] OP_LDI     = 32'd12;
  localparam logic [31:0] OP_SHL     = 32'd13;
  localparam logic [31:0] OP_SHR     = 32'd14;
  localparam logic [31:0] OP_ILLEGAL = 32'd15;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4
  } state_t;

  function automatic logic is_mem_op(input logic [31:0] opc);
    return opc <= OP_AND;
  endfunction

endpackage

// File: rtl/fbcpu_alu.sv
// Combinational ALU: computes the next ACC/Carry for the instruction being committed.
// Ops that do not touch ACC or Carry pass the current values through unchanged.
module fbcpu_alu
  import fbcpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic [31:0]              opcode,
  input  logic [DATA_WIDTH-1:0]    acc,
  input  logic [DATA_WIDTH-1:0]    mdr,
  input  logic [ADDRESS_WIDTH-1:0] op,
  input  logic                     carry,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     carry_out
);

  always_comb begin
    result    = acc;
    carry_out = carry;
    case (opcode)
      OP_LOAD: result = mdr;
      OP_ADD:  {carry_out, result} = {1'b0, acc} + {1'b0, mdr};
      OP_SUB: begin
        result    = acc - mdr;
        carry_out = acc < mdr;
      end
      OP_MUL:  result = acc * mdr;
      OP_AND:  result = acc & mdr;
      OP_LDI:  result = DATA_WIDTH'(op);
      OP_SHL: begin
        carry_out = acc[DATA_WIDTH-1];
        result    = {acc[DATA_WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        carry_out = acc[0];
        result    = {1'b0, acc[DATA_WIDTH-1:1]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fbcpu_v2_core.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC[/MEM] against a single-port synchronous RAM.
// MemReady low stalls DECODE and MEM with the bus held; reset forces every bus strobe low at once.
module fbcpu_v2_core
  import fbcpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int OPCODE_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    MDROut,
  input  logic                     MemReady,
  input  logic                     Resume,
  output logic [ADDRESS_WIDTH-1:0] MAR,
  output logic [DATA_WIDTH-1:0]    MDRIn,
  output logic                     RAMWr,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0]    ACC,
  output logic                     Carry,
  output logic                     Zero,
  output logic                     Halted,
  output logic                     IllegalOp
);

  if (DATA_WIDTH < OPCODE_WIDTH + ADDRESS_WIDTH) begin : g_bad_data_width
    $error("fbcpu_v2_core: DATA_WIDTH must hold opcode and operand fields");
  end
  if (OPCODE_WIDTH < 4) begin : g_bad_opcode_width
    $error("fbcpu_v2_core: OPCODE_WIDTH must be at least 4");
  end

  state_t                   state, state_nxt;
  logic [DATA_WIDTH-1:0]    ir;
  logic [31:0]              opc;
  logic [ADDRESS_WIDTH-1:0] op;
  logic                     mem_op, is_store, take_branch, alu_c;
  logic [DATA_WIDTH-1:0]    alu_res;

  assign opc      = 32'(ir[DATA_WIDTH-1 -: OPCODE_WIDTH]);
  assign op       = ir[ADDRESS_WIDTH-1:0];
  assign mem_op   = is_mem_op(opc);
  assign is_store = (opc == OP_STORE);
  assign Zero     = (ACC == '0);

  fbcpu_alu #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_alu (
    .opcode   (opc),
    .acc      (ACC),
    .mdr      (MDROut),
    .op       (op),
    .carry    (Carry),
    .result   (alu_res),
    .carry_out(alu_c)
  );

  always_comb begin
    take_branch = 1'b0;
    case (opc)
      OP_JMP:  take_branch = 1'b1;
      OP_JZ:   take_branch = (ACC == '0);
      OP_JNZ:  take_branch = (ACC != '0);
      OP_JC:   take_branch = Carry;
      default: take_branch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = DECODE;
      DECODE:  if (MemReady) state_nxt = EXEC;
      EXEC:    state_nxt = mem_op ? MEM : ((opc == OP_HALT) ? HALT : FETCH);
      MEM:     if (MemReady) state_nxt = FETCH;
      HALT:    if (Resume) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC    <= '0;
      ir    <= '0;
      ACC   <= '0;
      Carry <= 1'b0;
    end else begin
      case (state)
        DECODE: if (MemReady) begin
          ir <= MDROut;
          PC <= PC + ADDRESS_WIDTH'(1);
        end
        EXEC: if (!mem_op) begin
          ACC   <= alu_res;
          Carry <= alu_c;
          if (take_branch) PC <= op;
        end
        MEM: if (MemReady && !is_store) begin
          ACC   <= alu_res;
          Carry <= alu_c;
        end
        default: ;
      endcase
    end
  end

  // Gating on rst drops the write strobe the instant reset rises, even mid-STORE.
  always_comb begin
    MAR   = '0;
    MDRIn = '0;
    RAMWr = 1'b0;
    if (!rst) begin
      case (state)
        FETCH, DECODE: MAR = PC;
        EXEC: if (mem_op) MAR = op;
        MEM: begin
          MAR = op;
          if (is_store) begin
            MDRIn = ACC;
            RAMWr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Halted    = !rst && (state == HALT);
  assign IllegalOp = !rst && (state == EXEC) && (opc >= OP_ILLEGAL);

endmodule

// File: tb/tb_fbcpu_v2_core.sv
// Directed bench for fbcpu_v2_core with a behavioural synchronous RAM and hand-computed expectations.
module tb_fbcpu_v2_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] MDROut;
  logic       MemReady;
  logic       Resume;
  logic [5:0] MAR;
  logic [9:0] MDRIn;
  logic       RAMWr;
  logic [5:0] PC;
  logic [9:0] ACC;
  logic       Carry, Zero, Halted, IllegalOp;

  logic [9:0] mem [64];
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [9:0] ld_dat = '0;
  int         wr_cycles = 0;
  logic [5:0] wr_mar = '0;

  int checks = 0;
  int errors = 0;

  fbcpu_v2_core dut (
    .clk(clk), .rst(rst), .MDROut(MDROut), .MemReady(MemReady), .Resume(Resume),
    .MAR(MAR), .MDRIn(MDRIn), .RAMWr(RAMWr), .PC(PC), .ACC(ACC), .Carry(Carry),
    .Zero(Zero), .Halted(Halted), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_dat;
    else if (RAMWr && MemReady) mem[MAR] <= MDRIn;
    if (RAMWr) begin
      wr_cycles <= wr_cycles + 1;
      wr_mar    <= MAR;
    end
    MDROut <= mem[MAR];
  end

  function automatic logic [9:0] enc(input int opc, input int arg);
    logic [31:0] o, a;
    o = opc;
    a = arg;
    return {o[3:0], a[5:0]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input int a, input logic [9:0] d);
    ld_addr = 6'(a);
    ld_dat  = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic hold_reset;
    rst = 1'b1;
    MemReady = 1'b1;
    Resume = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    hold_reset();
    checks++; if (PC !== 6'd0) begin errors++; $display("FAIL rst_pc: got %0d expected 0", PC); end
    checks++; if (ACC !== 10'd0) begin errors++; $display("FAIL rst_acc: got %0d expected 0", ACC); end
    checks++; if (Carry !== 1'b0) begin errors++; $display("FAIL rst_carry: got %b expected 0", Carry); end
    checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL rst_zero: got %b expected 1", Zero); end
    checks++; if ({MAR, MDRIn, RAMWr, Halted, IllegalOp} !== 19'd0)
      begin errors++; $display("FAIL rst_bus: got mar=%0d mdrin=%0d wr=%b h=%b ill=%b expected all 0", MAR, MDRIn, RAMWr, Halted, IllegalOp); end
  endtask

  task automatic test_store_load;
    int wc;
    hold_reset();
    poke(0, enc(12, 5)); poke(1, enc(1, 40)); poke(2, enc(0, 40)); poke(3, enc(9, 0));
    poke(40, 10'd0);
    wc = wr_cycles;
    rst = 1'b0;
    step(13);
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL sl_early_halt: got %b expected 0", Halted); end
    step(1);
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL sl_halted: got %b expected 1", Halted); end
    checks++; if (PC !== 6'd4) begin errors++; $display("FAIL sl_pc: got %0d expected 4", PC); end
    checks++; if (ACC !== 10'd5) begin errors++; $display("FAIL sl_acc: got %0d expected 5", ACC); end
    checks++; if (mem[40] !== 10'd5) begin errors++; $display("FAIL sl_mem40: got %0d expected 5", mem[40]); end
    checks++; if (wr_cycles - wc !== 1) begin errors++; $display("FAIL sl_wr_cycles: got %0d expected 1", wr_cycles - wc); end
    checks++; if (wr_mar !== 6'd40) begin errors++; $display("FAIL sl_wr_mar: got %0d expected 40", wr_mar); end
  endtask

  task automatic test_arith;
    hold_reset();
    poke(20, 10'd1000); poke(21, 10'd50); poke(22, 10'd7); poke(23, 10'd40); poke(24, 10'd30);
    poke(0, enc(0, 20)); poke(1, enc(2, 21)); poke(2, enc(12, 5)); poke(3, enc(3, 22));
    poke(4, enc(12, 40)); poke(5, enc(4, 24)); poke(6, enc(9, 0));
    rst = 1'b0;
    step(4);
    checks++; if (ACC !== 10'd1000) begin errors++; $display("FAIL ar_load: got %0d expected 1000", ACC); end
    step(4);
    checks++; if ({Carry, ACC} !== {1'b1, 10'd26}) begin errors++; $display("FAIL ar_add: got c=%b acc=%0d expected c=1 acc=26", Carry, ACC); end
    step(7);
    checks++; if ({Carry, ACC} !== {1'b1, 10'd1022}) begin errors++; $display("FAIL ar_sub: got c=%b acc=%0d expected c=1 acc=1022", Carry, ACC); end
    step(7);
    checks++; if ({Carry, ACC} !== {1'b1, 10'd176}) begin errors++; $display("FAIL ar_mul: got c=%b acc=%0d expected c=1 acc=176", Carry, ACC); end
  endtask

  task automatic test_branch;
    hold_reset();
    poke(0, enc(12, 0)); poke(1, enc(7, 50));
    poke(50, enc(12, 3)); poke(51, enc(10, 10));
    poke(10, enc(12, 32));
    for (int i = 11; i <= 15; i++) poke(i, enc(13, 0));
    poke(16, enc(11, 7)); poke(7, enc(9, 0));
    rst = 1'b0;
    step(6);
    checks++; if (PC !== 6'd50) begin errors++; $display("FAIL br_jz: got %0d expected 50", PC); end
    step(6);
    checks++; if (PC !== 6'd10) begin errors++; $display("FAIL br_jnz: got %0d expected 10", PC); end
    step(15);
    checks++; if ({Carry, ACC} !== {1'b0, 10'd512}) begin errors++; $display("FAIL br_shl4: got c=%b acc=%0d expected c=0 acc=512", Carry, ACC); end
    step(3);
    checks++; if ({Carry, Zero, ACC} !== {1'b1, 1'b1, 10'd0}) begin errors++; $display("FAIL br_shl_out: got c=%b z=%b acc=%0d expected c=1 z=1 acc=0", Carry, Zero, ACC); end
    step(3);
    checks++; if (PC !== 6'd7) begin errors++; $display("FAIL br_jc: got %0d expected 7", PC); end
  endtask

  task automatic test_wait_states;
    logic [8:0] rdy;
    logic [5:0] exp_mar [9];
    logic [5:0] exp_pc  [9];
    rdy = 9'b100110001;  // index 0 is the FETCH cycle
    exp_mar = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd21, 6'd21, 6'd21, 6'd21};
    exp_pc  = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd2, 6'd2, 6'd2, 6'd2};
    hold_reset();
    poke(21, 10'd50);
    poke(0, enc(12, 10)); poke(1, enc(2, 21)); poke(2, enc(9, 0));
    rst = 1'b0;
    step(3);
    for (int i = 0; i < 9; i++) begin
      MemReady = rdy[i];
      #1;
      checks++; if (MAR !== exp_mar[i]) begin errors++; $display("FAIL ws_mar[%0d]: got %0d expected %0d", i, MAR, exp_mar[i]); end
      checks++; if (PC !== exp_pc[i]) begin errors++; $display("FAIL ws_pc[%0d]: got %0d expected %0d", i, PC, exp_pc[i]); end
      checks++; if (ACC !== 10'd10) begin errors++; $display("FAIL ws_acc_hold[%0d]: got %0d expected 10", i, ACC); end
      step(1);
    end
    MemReady = 1'b1;
    checks++; if ({Carry, ACC} !== {1'b0, 10'd60}) begin errors++; $display("FAIL ws_commit: got c=%b acc=%0d expected c=0 acc=60", Carry, ACC); end
  endtask

  task automatic test_misc;
    hold_reset();
    poke(0, enc(6, 63)); poke(63, enc(8, 0));
    rst = 1'b0;
    step(3);
    checks++; if (PC !== 6'd63) begin errors++; $display("FAIL mi_jmp63: got %0d expected 63", PC); end
    step(3);
    checks++; if (PC !== 6'd0) begin errors++; $display("FAIL mi_wrap: got %0d expected 0", PC); end

    hold_reset();
    poke(0, enc(12, 9)); poke(1, enc(15, 0)); poke(2, enc(9, 0));
    poke(3, enc(14, 0)); poke(4, enc(7, 20)); poke(5, enc(9, 0));
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++; if (IllegalOp !== (i == 5)) begin errors++; $display("FAIL mi_illegal[%0d]: got %b expected %b", i, IllegalOp, i == 5); end
      step(1);
    end
    checks++; if (ACC !== 10'd9) begin errors++; $display("FAIL mi_illegal_acc: got %0d expected 9", ACC); end
    checks++; if ({Halted, PC} !== {1'b1, 6'd3}) begin errors++; $display("FAIL mi_halt: got h=%b pc=%0d expected h=1 pc=3", Halted, PC); end
    step(2);
    checks++; if ({Halted, MAR, RAMWr} !== {1'b1, 6'd0, 1'b0}) begin errors++; $display("FAIL mi_halt_idle: got h=%b mar=%0d wr=%b expected h=1 mar=0 wr=0", Halted, MAR, RAMWr); end
    Resume = 1'b1;
    step(1);
    Resume = 1'b0;
    checks++; if ({Halted, MAR} !== {1'b0, 6'd3}) begin errors++; $display("FAIL mi_resume: got h=%b mar=%0d expected h=0 mar=3", Halted, MAR); end
    step(3);
    checks++; if ({Carry, ACC} !== {1'b1, 10'd4}) begin errors++; $display("FAIL mi_shr: got c=%b acc=%0d expected c=1 acc=4", Carry, ACC); end
    step(3);
    checks++; if (PC !== 6'd5) begin errors++; $display("FAIL mi_jz_not_taken: got %0d expected 5", PC); end
  endtask

  task automatic test_reset_mid_store;
    int wc;
    hold_reset();
    poke(45, 10'd0);
    poke(0, enc(12, 7)); poke(1, enc(1, 45));
    rst = 1'b0;
    step(6);
    checks++; if ({RAMWr, MAR, MDRIn} !== {1'b1, 6'd45, 10'd7}) begin errors++; $display("FAIL rm_store_bus: got wr=%b mar=%0d mdrin=%0d expected wr=1 mar=45 mdrin=7", RAMWr, MAR, MDRIn); end
    wc = wr_cycles;
    #2 rst = 1'b1;
    #1;
    checks++; if (RAMWr !== 1'b0) begin errors++; $display("FAIL rm_wr_drop: got %b expected 0", RAMWr); end
    checks++; if ({PC, ACC, Halted, MAR} !== 23'd0) begin errors++; $display("FAIL rm_regs: got pc=%0d acc=%0d h=%b mar=%0d expected all 0", PC, ACC, Halted, MAR); end
    @(negedge clk);
    checks++; if (wr_cycles - wc !== 0) begin errors++; $display("FAIL rm_no_write: got %0d write cycles expected 0", wr_cycles - wc); end
    checks++; if (mem[45] !== 10'd0) begin errors++; $display("FAIL rm_mem45: got %0d expected 0", mem[45]); end
    rst = 1'b0;
    #1;
    checks++; if (MAR !== 6'd0) begin errors++; $display("FAIL rm_refetch: got %0d expected 0", MAR); end
    step(3);
    checks++; if ({PC, ACC} !== {6'd1, 10'd7}) begin errors++; $display("FAIL rm_restart: got pc=%0d acc=%0d expected pc=1 acc=7", PC, ACC); end
  endtask

  initial begin
    rst = 1'b1;
    MemReady = 1'b1;
    Resume = 1'b0;
    test_reset();
    test_store_load();
    test_arith();
    test_branch();
    test_wait_states();
    test_misc();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
